kpn_add_process: RTL and testbench

Kahn Process Network compute node. It blocks on two upstream token FIFOs (A and B), reads one token from each, and adds them modulo 2^BITS_NUMBER. It then blocks on the downstream FIFO until it has room and writes the sum. The node sits between `fifo_module` instances: it drives their `rd`/`wr` strobes, consumes `output_1` of the upstream FIFOs and feeds `entry_1` of the downstream FIFO.

---
 rtl/kpn_add_process_if.sv | 25 ++
 rtl/kpn_add_process.sv | 105 ++++++++++
 tb/tb_kpn_add_process.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/kpn_add_process_if.sv
// Token-FIFO connections of the KPN adder node: two upstream read ports and
// one downstream write port. The node takes the master side and the FIFOs take the slave side.
interface kpn_add_process_if #(
    parameter int BITS_NUMBER = 16
);
    logic                   empty_a;
    logic                   rd_a;
    logic [BITS_NUMBER-1:0] entry_a;
    logic                   empty_b;
    logic                   rd_b;
    logic [BITS_NUMBER-1:0] entry_b;
    logic                   full_out;
    logic                   wr_out;
    logic [BITS_NUMBER-1:0] output_1;

    modport master (
        input  empty_a, entry_a, empty_b, entry_b, full_out,
        output rd_a, rd_b, wr_out, output_1
    );

    modport slave (
        output empty_a, entry_a, empty_b, entry_b, full_out,
        input  rd_a, rd_b, wr_out, output_1
    );
endinterface

// File: rtl/kpn_add_process.sv
// Kahn process network node that blocks on FIFOs A and B, adds one token from
// each modulo 2^BITS_NUMBER, then blocks on the output FIFO and writes the sum.
module kpn_add_process #(
    parameter int BITS_NUMBER = 16,
    parameter int COUNT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    kpn_add_process_if.master     bus,
    output logic                  overflow,
    output logic [COUNT_BITS-1:0] tokens_done
);

    localparam logic [2:0] WAIT_A   = 3'd0;
    localparam logic [2:0] RD_A     = 3'd1;
    localparam logic [2:0] LATCH_A  = 3'd2;
    localparam logic [2:0] WAIT_B   = 3'd3;
    localparam logic [2:0] RD_B     = 3'd4;
    localparam logic [2:0] LATCH_B  = 3'd5;
    localparam logic [2:0] WAIT_OUT = 3'd6;
    localparam logic [2:0] WR       = 3'd7;

    logic [2:0]             state_q,    state_d;
    logic [BITS_NUMBER-1:0] op_a_q,     op_a_d;
    logic [BITS_NUMBER-1:0] sum_q,      sum_d;
    logic                   overflow_q, overflow_d;
    logic [COUNT_BITS-1:0]  tokens_q,   tokens_d;
    logic [BITS_NUMBER:0]   add_full;

    // FIFO inputs are only examined in the state that waits on them.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        tokens_d   = tokens_q;
        add_full   = {1'b0, op_a_q} + {1'b0, bus.entry_b};
        case (state_q)
            WAIT_A: begin
                if (!bus.empty_a) begin
                    state_d = RD_A;
                end
            end
            RD_A: begin
                state_d = LATCH_A;
            end
            LATCH_A: begin
                op_a_d  = bus.entry_a;
                state_d = WAIT_B;
            end
            WAIT_B: begin
                if (!bus.empty_b) begin
                    state_d = RD_B;
                end
            end
            RD_B: begin
                state_d = LATCH_B;
            end
            LATCH_B: begin
                sum_d = add_full[BITS_NUMBER-1:0];
                if (add_full[BITS_NUMBER]) begin
                    overflow_d = 1'b1;
                end
                state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (!bus.full_out) begin
                    state_d = WR;
                end
            end
            WR: begin
                tokens_d = tokens_q + COUNT_BITS'(1);
                state_d  = WAIT_A;
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_A;
            op_a_q     <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            tokens_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            tokens_q   <= tokens_d;
        end
    end

    // Strobes come straight from the state register, so they are glitch-free and mutually exclusive.
    assign bus.rd_a     = (state_q == RD_A);
    assign bus.rd_b     = (state_q == RD_B);
    assign bus.wr_out   = (state_q == WR);
    assign bus.output_1 = sum_q;
    assign overflow     = overflow_q;
    assign tokens_done  = tokens_q;

endmodule

// File: tb/tb_kpn_add_process.sv
// Directed self-checking bench for kpn_add_process, with behavioural upstream
// FIFOs and a strobe-width/exclusivity monitor.
module tb_kpn_add_process;

    localparam int BW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          overflow;
    logic [CW-1:0] tokens_done;

    always #5 clk = ~clk;

    kpn_add_process_if #(.BITS_NUMBER(BW)) bus ();

    kpn_add_process #(.BITS_NUMBER(BW), .COUNT_BITS(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .overflow   (overflow),
        .tokens_done(tokens_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [BW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    int wr_cnt       = 0;
    int width_viol   = 0;
    int overlap_viol = 0;

    // Upstream FIFO model and strobe monitor; runs just after each falling edge.
    initial begin
        logic prev_a, prev_b, prev_w;
        prev_a = 1'b0; prev_b = 1'b0; prev_w = 1'b0;
        bus.empty_a = 1'b1;
        bus.empty_b = 1'b1;
        bus.entry_a = '0;
        bus.entry_b = '0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.rd_a && qa.size() > 0) bus.entry_a = qa.pop_front();
            if (bus.rd_b && qb.size() > 0) bus.entry_b = qb.pop_front();
            bus.empty_a = (qa.size() == 0);
            bus.empty_b = (qb.size() == 0);
            if (bus.wr_out) wr_cnt++;
            if ((bus.rd_a && prev_a) || (bus.rd_b && prev_b) || (bus.wr_out && prev_w)) width_viol++;
            if (int'(bus.rd_a) + int'(bus.rd_b) + int'(bus.wr_out) > 1) overlap_viol++;
            prev_a = bus.rd_a;
            prev_b = bus.rd_b;
            prev_w = bus.wr_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        qa.delete();
        qb.delete();
        repeat (3) @(negedge clk);
        checkOutput("reset_strobes", 32'({bus.rd_a, bus.rd_b, bus.wr_out}), 32'd0);
        checkOutput("reset_output", 32'(bus.output_1), 32'd0);
        checkOutput("reset_flags", 32'({overflow, tokens_done}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // which: 0 = rd_a, 1 = rd_b, 2 = wr_out
    task automatic waitStrobe(input int which, input string tag);
        int   n;
        logic hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? bus.rd_a : (which == 1) ? bus.rd_b : bus.wr_out;
        end while (!hit && n < 200);
        if (!hit) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expectWrite(input string tag, input logic [BW-1:0] expected);
        waitStrobe(2, tag);
        checkOutput(tag, 32'(bus.output_1), 32'(expected));
    endtask

    // Best-case firing from WAIT_A with empty output FIFO: strobe trace over cycles 1..8.
    task automatic applyStimulus(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                                 input logic [BW-1:0] sum);
        logic [23:0]   trace;
        logic [BW-1:0] out7;
        qa.push_back(a);
        qb.push_back(b);
        trace = '0;
        out7  = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            trace = {trace[20:0], bus.rd_a, bus.rd_b, bus.wr_out};
            if (c == 7) out7 = bus.output_1;
        end
        checkOutput({tag, "_trace"}, 32'(trace), 32'(24'b100_000_000_010_000_000_001_000));
        checkOutput({tag, "_sum"}, 32'(out7), 32'(sum));
        checkOutput({tag, "_tokens"}, 32'(tokens_done), 32'd1);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int seen_a, seen_b, seen_w, hold_bad, wr_snap;
        bus.full_out = 1'b0;

        applyReset();
        applyStimulus("basic", 16'd3, 16'd4, 16'd7);

        qa.push_back(16'hFFFF); qb.push_back(16'h0002);
        expectWrite("wrap_sum", 16'h0001);
        checkOutput("wrap_overflow", 32'(overflow), 32'd1);
        qa.push_back(16'd1); qb.push_back(16'd1);
        expectWrite("sticky_sum", 16'd2);
        @(negedge clk);
        checkOutput("sticky_overflow", 32'(overflow), 32'd1);
        checkOutput("sticky_tokens", 32'(tokens_done), 32'd3);

        qa.push_back(16'd10); qa.push_back(16'd99);
        waitStrobe(0, "block_rda");
        seen_a = 0; seen_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_a) seen_a++;
            if (bus.rd_b) seen_b++;
        end
        checkOutput("block_no_rdb", 32'(seen_b), 32'd0);
        checkOutput("block_no_rda", 32'(seen_a), 32'd0);
        qb.push_back(16'd5);
        expectWrite("block_sum", 16'd15);
        qb.push_back(16'd1);
        expectWrite("block_next_sum", 16'd100);

        bus.full_out = 1'b1;
        qa.push_back(16'd20); qb.push_back(16'd30);
        qa.push_back(16'd7);  qb.push_back(16'd8);
        waitStrobe(1, "bp_rdb");
        repeat (2) @(negedge clk);
        seen_a = 0; seen_b = 0; seen_w = 0; hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rd_a) seen_a++;
            if (bus.rd_b) seen_b++;
            if (bus.wr_out) seen_w++;
            if (bus.output_1 !== 16'd50) hold_bad++;
        end
        checkOutput("bp_no_write", 32'(seen_w), 32'd0);
        checkOutput("bp_no_reads", 32'(seen_a + seen_b), 32'd0);
        checkOutput("bp_hold", 32'(hold_bad), 32'd0);
        wr_snap = wr_cnt;
        bus.full_out = 1'b0;
        expectWrite("bp_sum", 16'd50);
        expectWrite("bp_next_sum", 16'd15);
        @(negedge clk);
        checkOutput("bp_writes", 32'(wr_cnt - wr_snap), 32'd2);
        checkOutput("bp_tokens", 32'(tokens_done), 32'd7);

        applyReset();
        wr_snap = wr_cnt;
        for (int i = 0; i < 32; i++) begin
            qa.push_back(BW'(i));
            qb.push_back(BW'(2 * i));
        end
        for (int i = 0; i < 32; i++) begin
            expectWrite($sformatf("stream_%0d", i), BW'(3 * i));
        end
        @(negedge clk);
        checkOutput("stream_tokens", 32'(tokens_done), 32'd32);
        checkOutput("stream_writes", 32'(wr_cnt - wr_snap), 32'd32);
        checkOutput("stream_overflow", 32'(overflow), 32'd0);

        qa.push_back(16'd5); qb.push_back(16'd6);
        waitStrobe(1, "midrst_rdb");
        @(posedge clk);
        #1;
        wr_snap = wr_cnt;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_strobes", 32'({bus.rd_a, bus.rd_b, bus.wr_out}), 32'd0);
        checkOutput("midrst_output", 32'(bus.output_1), 32'd0);
        checkOutput("midrst_flags", 32'({overflow, tokens_done}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_write", 32'(wr_cnt - wr_snap), 32'd0);
        applyStimulus("post_reset", 16'd3, 16'd4, 16'd7);

        checkOutput("strobe_width", 32'(width_viol), 32'd0);
        checkOutput("strobe_overlap", 32'(overlap_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
